// File: rtl/seg7_pkg.sv
// Shared character codes, segment patterns and the char->segment decode
// used by the 7-segment display blocks.
package seg7_pkg;

    localparam logic [4:0] CH_BLANK = 5'h10;
    localparam logic [4:0] CH_DASH  = 5'h11;
    localparam logic [4:0] CH_T     = 5'h12;
    localparam logic [4:0] CH_R     = 5'h13;
    localparam logic [4:0] CH_P     = 5'h14;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DASH  = 8'h02;
    localparam logic [7:0] SEG_T     = 8'h1E;
    localparam logic [7:0] SEG_R     = 8'h0A;
    localparam logic [7:0] SEG_P     = 8'hCE;

    // Hex glyphs {a,b,c,d,e,f,g,dp}; element 0 is the rightmost entry.
    localparam logic [15:0][7:0] SEG_HEX = {
        8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
        8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
    };

    function automatic logic [7:0] seg7_decode(input logic [4:0] ch);
        logic [7:0] seg;
        if (!ch[4]) begin
            seg = SEG_HEX[ch[3:0]];
        end else begin
            case (ch)
                CH_DASH: seg = SEG_DASH;
                CH_T:    seg = SEG_T;
                CH_R:    seg = SEG_R;
                CH_P:    seg = SEG_P;
                default: seg = SEG_BLANK;
            endcase
        end
        return seg;
    endfunction

endpackage

// File: rtl/seg7_char_decoder.sv
// Combinational character + decimal point to segment pattern decoder.
module seg7_char_decoder
    import seg7_pkg::*;
(
    input  logic [4:0] char_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = seg7_decode(char_i) | {7'b0, dp_i};
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed N-digit 7-segment scan controller with per-digit register file,
// PWM brightness, frame-synchronous blinking and a sequential clear sweep.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter  int NUM_DIGITS   = 8,
    parameter  int SCAN_CYCLES  = 32768,
    parameter  int BRIGHT_W     = 3,
    parameter  int BLINK_FRAMES = 64,
    localparam int AW           = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [4:0]            i_wr_char,
    input  logic                  i_wr_dp,
    input  logic                  i_wr_blink,
    input  logic                  i_clear,
    input  logic [BRIGHT_W-1:0]   i_bright,
    output logic [7:0]            seg_data,
    output logic [NUM_DIGITS-1:0] seg_sel,
    output logic                  o_frame_done,
    output logic                  o_wr_err
);

    localparam int PW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_CYCLES - 1);
    localparam logic [AW-1:0] IDX_LAST   = AW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [AW:0]   DIGITS     = (AW+1)'(NUM_DIGITS);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [4:0]            char_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dp_q, blink_q;
    logic [0:0]            state_q, state_d;
    logic [AW-1:0]         clr_idx_q, clr_idx_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [FW-1:0]         frame_q, frame_d;
    logic                  blink_ph_q, blink_ph_d;
    logic [7:0]            seg_data_q;
    logic [NUM_DIGITS-1:0] seg_sel_q;
    logic                  frame_done_q, wr_err_q;

    logic       wr_accept, wr_in_range, presc_wrap, idx_wrap, lit;
    logic [7:0] glyph;

    seg7_char_decoder u_dec (
        .char_i (char_q[idx_q]),
        .dp_i   (dp_q[idx_q]),
        .seg_o  (glyph)
    );

    always_comb begin
        wr_accept   = i_wr_valid && (state_q == ST_IDLE);
        wr_in_range = {1'b0, i_wr_addr} < DIGITS;
        presc_wrap  = (presc_q == PRESC_LAST);
        idx_wrap    = presc_wrap && (idx_q == IDX_LAST);
        lit         = (presc_q[BRIGHT_W-1:0] <= i_bright) && !(blink_q[idx_q] && blink_ph_q);

        presc_d    = presc_q;
        idx_d      = idx_q;
        frame_d    = frame_q;
        blink_ph_d = blink_ph_q;
        if (i_en) begin
            presc_d = presc_wrap ? '0 : presc_q + 1'b1;
            if (presc_wrap) begin
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
            if (idx_wrap) begin
                if (frame_q == FRAME_LAST) begin
                    frame_d    = '0;
                    blink_ph_d = ~blink_ph_q;
                end else begin
                    frame_d = frame_q + 1'b1;
                end
            end
        end

        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_IDLE) begin
            if (i_clear) begin
                state_d   = ST_CLEAR;
                clr_idx_d = '0;
            end
        end else begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == IDX_LAST) begin
                state_d   = ST_IDLE;
                clr_idx_d = '0;
            end
        end
    end

    // Writes are only accepted in IDLE, so the sweep never collides with a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                char_q[k] <= CH_BLANK;
            end
            dp_q    <= '0;
            blink_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            char_q[clr_idx_q]  <= CH_BLANK;
            dp_q[clr_idx_q]    <= 1'b0;
            blink_q[clr_idx_q] <= 1'b0;
        end else if (wr_accept && wr_in_range) begin
            char_q[i_wr_addr]  <= i_wr_char;
            dp_q[i_wr_addr]    <= i_wr_dp;
            blink_q[i_wr_addr] <= i_wr_blink;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            clr_idx_q    <= '0;
            presc_q      <= '0;
            idx_q        <= '0;
            frame_q      <= '0;
            blink_ph_q   <= 1'b0;
            seg_data_q   <= '0;
            seg_sel_q    <= '0;
            frame_done_q <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            frame_q      <= frame_d;
            blink_ph_q   <= blink_ph_d;
            frame_done_q <= i_en && idx_wrap;
            wr_err_q     <= wr_accept && !wr_in_range;
            if (i_en && lit) begin
                seg_sel_q  <= NUM_DIGITS'(1) << idx_q;
                seg_data_q <= glyph;
            end else begin
                seg_sel_q  <= '0;
                seg_data_q <= '0;
            end
        end
    end

    assign o_wr_ready   = (state_q == ST_IDLE);
    assign seg_data     = seg_data_q;
    assign seg_sel      = seg_sel_q;
    assign o_frame_done = frame_done_q;
    assign o_wr_err     = wr_err_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: arithmetic reference model driven
// per cycle, decode vector table, directed corner sequences and random traffic.
module tb_seg7_scan_ctrl;

    localparam int N  = 4;
    localparam int SC = 8;
    localparam int BW = 2;
    localparam int BF = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       en, wr_valid, dp, blink, clear;
    logic [1:0] addr, bright;
    logic [4:0] ch;
    logic       wr_ready, frame_done, wr_err;
    logic [7:0] seg_data;
    logic [3:0] seg_sel;

    logic       en2, wr_valid2, clear2;
    logic [2:0] addr2;
    logic       wr_ready2, frame_done2, wr_err2;
    logic [7:0] seg_data2;
    logic [4:0] seg_sel2;

    seg7_scan_ctrl #(.NUM_DIGITS(N), .SCAN_CYCLES(SC), .BRIGHT_W(BW), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .i_en(en), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
        .i_wr_addr(addr), .i_wr_char(ch), .i_wr_dp(dp), .i_wr_blink(blink), .i_clear(clear),
        .i_bright(bright), .seg_data(seg_data), .seg_sel(seg_sel),
        .o_frame_done(frame_done), .o_wr_err(wr_err)
    );

    // Five digits so that an out-of-range address is expressible on the 3-bit port.
    seg7_scan_ctrl #(.NUM_DIGITS(5), .SCAN_CYCLES(SC), .BRIGHT_W(BW), .BLINK_FRAMES(BF)) dut5 (
        .clk(clk), .rst_n(rst_n), .i_en(en2), .i_wr_valid(wr_valid2), .o_wr_ready(wr_ready2),
        .i_wr_addr(addr2), .i_wr_char(ch), .i_wr_dp(dp), .i_wr_blink(blink), .i_clear(clear2),
        .i_bright(bright), .seg_data(seg_data2), .seg_sel(seg_sel2),
        .o_frame_done(frame_done2), .o_wr_err(wr_err2)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: n counts enabled cycles since reset; slot, digit, frame
    // and blink phase all follow from it by division.
    int         n;
    int         clr_k;
    logic [4:0] m_ch [N];
    logic       m_dp [N];
    logic       m_bl [N];

    function automatic logic [7:0] ref_glyph(input logic [4:0] c);
        case (c)
            5'h00: return 8'hFC;  5'h01: return 8'h60;  5'h02: return 8'hDA;  5'h03: return 8'hF2;
            5'h04: return 8'h66;  5'h05: return 8'hB6;  5'h06: return 8'hBE;  5'h07: return 8'hE0;
            5'h08: return 8'hFE;  5'h09: return 8'hF6;  5'h0A: return 8'hEE;  5'h0B: return 8'h3E;
            5'h0C: return 8'h9C;  5'h0D: return 8'h7A;  5'h0E: return 8'h9E;  5'h0F: return 8'h8E;
            5'h11: return 8'h02;  5'h12: return 8'h1E;  5'h13: return 8'h0A;  5'h14: return 8'hCE;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        n = 0;
        clr_k = -1;
        for (int i = 0; i < N; i++) begin
            m_ch[i] = 5'h10;
            m_dp[i] = 1'b0;
            m_bl[i] = 1'b0;
        end
    endtask

    task automatic tick();
        logic [7:0] e_data;
        logic [3:0] e_sel;
        logic       e_fd, e_err, e_rdy, acc, lit;
        int         p, idx, frame, ph;
        acc    = wr_valid && (clr_k < 0);
        e_data = 8'h00;
        e_sel  = 4'h0;
        e_fd   = 1'b0;
        if (en) begin
            p     = n % SC;
            idx   = (n / SC) % N;
            frame = n / (SC * N);
            ph    = (frame / BF) % 2;
            lit   = ((p % (1 << BW)) <= int'(bright)) && !(m_bl[idx] && ph == 1);
            if (lit) begin
                e_sel  = 4'(1 << idx);
                e_data = ref_glyph(m_ch[idx]) | {7'b0, m_dp[idx]};
            end
            e_fd = ((n + 1) % (SC * N)) == 0;
            n++;
        end
        e_err = acc && (int'(addr) >= N);
        if (acc) begin
            m_ch[addr] = ch;
            m_dp[addr] = dp;
            m_bl[addr] = blink;
        end
        if (clr_k >= 0) begin
            m_ch[clr_k] = 5'h10;
            m_dp[clr_k] = 1'b0;
            m_bl[clr_k] = 1'b0;
            clr_k++;
            if (clr_k == N) clr_k = -1;
        end else if (clear) begin
            clr_k = 0;
        end
        e_rdy = (clr_k < 0);
        @(posedge clk);
        #1;
        check("seg_data", 32'(seg_data), 32'(e_data));
        check("seg_sel", 32'(seg_sel), 32'(e_sel));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("wr_ready", 32'(wr_ready), 32'(e_rdy));
        check("wr_err", 32'(wr_err), 32'(e_err));
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [4:0] c, input logic d, input logic b);
        addr = a; ch = c; dp = d; blink = b; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    typedef struct {
        logic [4:0] c;
        logic       d;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [12];

    int  fd_count, lit_count, low, bound_hit;
    logic found, any_lit;

    initial begin
        vecs[0]  = '{5'h00, 1'b0, 8'hFC};
        vecs[1]  = '{5'h05, 1'b1, 8'hB7};
        vecs[2]  = '{5'h0A, 1'b0, 8'hEE};
        vecs[3]  = '{5'h0F, 1'b0, 8'h8E};
        vecs[4]  = '{5'h08, 1'b1, 8'hFF};
        vecs[5]  = '{5'h10, 1'b1, 8'h01};
        vecs[6]  = '{5'h11, 1'b0, 8'h02};
        vecs[7]  = '{5'h12, 1'b0, 8'h1E};
        vecs[8]  = '{5'h13, 1'b0, 8'h0A};
        vecs[9]  = '{5'h14, 1'b1, 8'hCF};
        vecs[10] = '{5'h15, 1'b0, 8'h00};
        vecs[11] = '{5'h1F, 1'b0, 8'h00};

        en = 0; wr_valid = 0; dp = 0; blink = 0; clear = 0; addr = 0; bright = 0; ch = 0;
        en2 = 0; wr_valid2 = 0; clear2 = 0; addr2 = 0;
        model_reset();

        #2 rst_n = 1'b0;
        #10;
        check("rst_seg_data", 32'(seg_data), 32'h0);
        check("rst_seg_sel", 32'(seg_sel), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_wr_err", 32'(wr_err), 32'h0);
        check("rst_wr_ready", 32'(wr_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Blank scan at full brightness, frame pulse every 32 cycles.
        en = 1; bright = 3;
        fd_count = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (frame_done) fd_count++;
        end
        check("frame_done_count", 32'(fd_count), 32'd2);

        wr(2'd0, 5'h05, 1'b1, 1'b0);
        wr(2'd2, 5'h0A, 1'b0, 1'b0);
        run(64);

        // Brightness 1 lights exactly half of every window.
        bright = 1;
        lit_count = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (seg_sel != 4'h0) lit_count++;
        end
        check("dim_lit_count", 32'(lit_count), 32'd16);
        bright = 3;

        wr(2'd1, 5'h12, 1'b0, 1'b1);
        run(5 * SC * N);

        // Decode table through digit 0.
        for (int v = 0; v < 12; v++) begin
            wr(2'd0, vecs[v].c, vecs[v].d, 1'b0);
            tick();
            found = 1'b0;
            for (int t = 0; t < 40 && !found; t++) begin
                tick();
                if (seg_sel == 4'b0001) found = 1'b1;
            end
            check("vec_digit0_seen", 32'(found), 32'h1);
            check("vec_glyph", 32'(seg_data), 32'(vecs[v].exp));
        end

        // Clear with a simultaneous write, then a write held through the sweep.
        addr = 2'd3; ch = 5'h11; dp = 0; blink = 0; wr_valid = 1; clear = 1;
        tick();
        clear = 0; addr = 2'd2; ch = 5'h14; dp = 1;
        low = 0;
        bound_hit = 1;
        for (int t = 0; t < 10; t++) begin
            if (wr_ready) begin
                bound_hit = 0;
                break;
            end
            low++;
            tick();
        end
        check("clear_ready_bounded", 32'(bound_hit), 32'h0);
        check("clear_ready_low", 32'(low), 32'd4);
        tick();
        wr_valid = 0;
        dp = 0;
        run(2 * SC * N);

        // Clear pulse while clearing is ignored.
        clear = 1;
        tick();
        tick();
        clear = 0;
        run(12);

        // Out-of-range write on the five-digit instance.
        en2 = 1; addr2 = 3'd5; ch = 5'h08; dp = 1; wr_valid2 = 1;
        tick();
        wr_valid2 = 0;
        check("oor_err_pulse", 32'(wr_err2), 32'h1);
        tick();
        check("oor_err_single", 32'(wr_err2), 32'h0);
        any_lit = 1'b0;
        for (int t = 0; t < 5 * SC + 2; t++) begin
            tick();
            if (seg_data2 != 8'h00) any_lit = 1'b1;
        end
        check("oor_display_unchanged", 32'(any_lit), 32'h0);
        addr2 = 3'd4; wr_valid2 = 1;
        tick();
        wr_valid2 = 0;
        check("inrange_no_err", 32'(wr_err2), 32'h0);
        dp = 0;

        // Mid-slot enable drop and resume.
        run(3);
        en = 0;
        tick();
        check("en_off_sel", 32'(seg_sel), 32'h0);
        run(5);
        en = 1;
        run(40);

        // Asynchronous reset in the middle of a clear sweep.
        clear = 1;
        tick();
        clear = 0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(wr_ready), 32'h1);
        check("midrst_sel", 32'(seg_sel), 32'h0);
        check("midrst_data", 32'(seg_data), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(40);

        // Random traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            wr_valid = ($urandom_range(0, 4) == 0);
            addr     = 2'($urandom_range(0, 3));
            ch       = 5'($urandom_range(0, 31));
            dp       = 1'($urandom_range(0, 1));
            blink    = 1'($urandom_range(0, 1));
            clear    = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 31) == 0) bright = 2'($urandom_range(0, 3));
            tick();
        end
        wr_valid = 0;
        clear = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
